// File: rtl/dns_query_parse.sv
// dns_query_parse
// Takes one flattened DNS-over-UDP payload, validates the fixed header,
// walks the first question's QNAME one byte per cycle while folding it into
// a case-insensitive FNV-1a hash, then presents the parsed query (or an
// error code) on a valid/ready result port.
module dns_query_parse #(
  parameter int          MAX_QNAME = 255,
  parameter logic [31:0] HASH_INIT = 32'h811C9DC5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_dns_valid,
  output logic          s_dns_ready,
  input  logic [31:0]   s_udp_src_ip,
  input  logic [31:0]   s_udp_dst_ip,
  input  logic [15:0]   s_udp_length,
  input  logic [4095:0] s_dns_pkt,
  output logic          m_query_valid,
  input  logic          m_query_ready,
  output logic [31:0]   m_src_ip,
  output logic [31:0]   m_dst_ip,
  output logic [15:0]   m_dns_id,
  output logic [15:0]   m_dns_flags,
  output logic [15:0]   m_qtype,
  output logic [15:0]   m_qclass,
  output logic [7:0]    m_qname_len,
  output logic [31:0]   m_qname_hash,
  output logic          m_error,
  output logic [2:0]    m_error_code
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_HDR        = 3'd1,
    S_LABEL_LEN  = 3'd2,
    S_LABEL_DATA = 3'd3,
    S_QTAIL      = 3'd4,
    S_OUT        = 3'd5
  } state_t;

  localparam logic [2:0] ERR_OK          = 3'd0;
  localparam logic [2:0] ERR_SHORT       = 3'd1;
  localparam logic [2:0] ERR_NOT_QUERY   = 3'd2;
  localparam logic [2:0] ERR_NO_QUESTION = 3'd3;
  localparam logic [2:0] ERR_BAD_LABEL   = 3'd4;
  localparam logic [2:0] ERR_TRUNC       = 3'd5;
  localparam logic [2:0] ERR_TOO_LONG    = 3'd6;

  // Four consecutive payload bytes starting at byte idx; byte 0 sits at [4087:4080].
  function automatic logic [31:0] window_at(input logic [4095:0] pkt, input logic [9:0] idx);
    logic [4095:0] sh;
    sh = pkt << {idx, 3'b000};
    return sh[4087:4056];
  endfunction

  // One FNV-1a step with ASCII upper-case letters folded to lower case.
  function automatic logic [31:0] fnv_step(input logic [31:0] h, input logic [7:0] b);
    logic [7:0] f;
    if ((b >= 8'h41) && (b <= 8'h5A)) begin
      f = b + 8'h20;
    end else begin
      f = b;
    end
    return (h ^ {24'h000000, f}) * 32'h01000193;
  endfunction

  state_t          state_r, state_next_s;
  logic [4095:0]   pkt_r;
  logic [31:0]     src_ip_r, dst_ip_r;
  logic [9:0]      plen_r, plen_in_s;
  logic [9:0]      ptr_r, ptr_next_s;
  logic [31:0]     hash_r, hash_next_s;
  logic [7:0]      qlen_r, qlen_next_s;
  logic [5:0]      rem_r, rem_next_s;
  logic [15:0]     udp_len_m8_s;
  logic [31:0]     win_s;
  logic [7:0]      cur_byte_s;
  logic [15:0]     hdr_id_s, hdr_flags_s, qdcount_s;
  logic [9:0]      label_sum_s;
  logic            accept_s;
  logic            load_out_s;
  logic [2:0]      code_s;
  logic [15:0]     qtype_s, qclass_s;

  logic            s_dns_ready_r, m_query_valid_r, m_error_r;
  logic [15:0]     m_dns_id_r, m_dns_flags_r, m_qtype_r, m_qclass_r;
  logic [7:0]      m_qname_len_r;
  logic [31:0]     m_qname_hash_r;
  logic [2:0]      m_error_code_r;

  assign accept_s     = s_dns_valid && s_dns_ready_r;
  assign win_s        = window_at(pkt_r, ptr_r);
  assign cur_byte_s   = win_s[31:24];
  assign hdr_id_s     = pkt_r[4087:4072];
  assign hdr_flags_s  = pkt_r[4071:4056];
  assign qdcount_s    = pkt_r[4055:4040];
  assign label_sum_s  = {2'b00, qlen_r} + 10'd1 + {2'b00, cur_byte_s};
  assign udp_len_m8_s = s_udp_length - 16'd8;

  // Payload length after the UDP header, clamped to the 511 bytes carried.
  always_comb begin
    plen_in_s = 10'd0;
    if (s_udp_length < 16'd8) begin
      plen_in_s = 10'd0;
    end else if (udp_len_m8_s > 16'd511) begin
      plen_in_s = 10'd511;
    end else begin
      plen_in_s = udp_len_m8_s[9:0];
    end
  end

  // Next-state and datapath update for the parse walk.
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    hash_next_s  = hash_r;
    qlen_next_s  = qlen_r;
    rem_next_s   = rem_r;
    load_out_s   = 1'b0;
    code_s       = ERR_OK;
    qtype_s      = 16'h0000;
    qclass_s     = 16'h0000;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_next_s = S_HDR;
          ptr_next_s   = 10'd12;
          hash_next_s  = HASH_INIT;
          qlen_next_s  = 8'd0;
          rem_next_s   = 6'd0;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_HDR: begin
        if (plen_r < 10'd17) begin
          code_s       = ERR_SHORT;
          load_out_s   = 1'b1;
          state_next_s = S_OUT;
        end else if (hdr_flags_s[15] || (hdr_flags_s[14:11] != 4'd0)) begin
          code_s       = ERR_NOT_QUERY;
          load_out_s   = 1'b1;
          state_next_s = S_OUT;
        end else if (qdcount_s == 16'd0) begin
          code_s       = ERR_NO_QUESTION;
          load_out_s   = 1'b1;
          state_next_s = S_OUT;
        end else begin
          state_next_s = S_LABEL_LEN;
        end
      end
      S_LABEL_LEN: begin
        if (ptr_r >= plen_r) begin
          code_s       = ERR_TRUNC;
          load_out_s   = 1'b1;
          state_next_s = S_OUT;
        end else if (cur_byte_s[7:6] != 2'b00) begin
          // Compression pointers and reserved label types are rejected.
          code_s       = ERR_BAD_LABEL;
          load_out_s   = 1'b1;
          state_next_s = S_OUT;
        end else if (label_sum_s > 10'(MAX_QNAME)) begin
          code_s       = ERR_TOO_LONG;
          load_out_s   = 1'b1;
          state_next_s = S_OUT;
        end else begin
          hash_next_s = fnv_step(hash_r, cur_byte_s);
          qlen_next_s = qlen_r + 8'd1;
          ptr_next_s  = ptr_r + 10'd1;
          if (cur_byte_s == 8'd0) begin
            state_next_s = S_QTAIL;
          end else begin
            rem_next_s   = cur_byte_s[5:0];
            state_next_s = S_LABEL_DATA;
          end
        end
      end
      S_LABEL_DATA: begin
        if (ptr_r >= plen_r) begin
          code_s       = ERR_TRUNC;
          load_out_s   = 1'b1;
          state_next_s = S_OUT;
        end else begin
          hash_next_s = fnv_step(hash_r, cur_byte_s);
          qlen_next_s = qlen_r + 8'd1;
          ptr_next_s  = ptr_r + 10'd1;
          rem_next_s  = rem_r - 6'd1;
          if (rem_r == 6'd1) begin
            state_next_s = S_LABEL_LEN;
          end else begin
            state_next_s = S_LABEL_DATA;
          end
        end
      end
      S_QTAIL: begin
        load_out_s   = 1'b1;
        state_next_s = S_OUT;
        if ((ptr_r + 10'd4) > plen_r) begin
          code_s = ERR_TRUNC;
        end else begin
          code_s   = ERR_OK;
          qtype_s  = win_s[31:16];
          qclass_s = win_s[15:0];
        end
      end
      S_OUT: begin
        if (m_query_ready) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_OUT;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State, walk pointer, hash and per-packet side data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      ptr_r    <= 10'd0;
      hash_r   <= 32'h00000000;
      qlen_r   <= 8'd0;
      rem_r    <= 6'd0;
      plen_r   <= 10'd0;
      src_ip_r <= 32'h00000000;
      dst_ip_r <= 32'h00000000;
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
      hash_r  <= hash_next_s;
      qlen_r  <= qlen_next_s;
      rem_r   <= rem_next_s;
      if (accept_s) begin
        plen_r   <= plen_in_s;
        src_ip_r <= s_udp_src_ip;
        dst_ip_r <= s_udp_dst_ip;
      end
    end
  end

  // Payload capture; contents only matter after an accept.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      pkt_r <= s_dns_pkt;
    end
  end

  // Handshake flags and result registers, loaded once on entry to OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_dns_ready_r   <= 1'b0;
      m_query_valid_r <= 1'b0;
      m_dns_id_r      <= 16'h0000;
      m_dns_flags_r   <= 16'h0000;
      m_qtype_r       <= 16'h0000;
      m_qclass_r      <= 16'h0000;
      m_qname_len_r   <= 8'd0;
      m_qname_hash_r  <= 32'h00000000;
      m_error_r       <= 1'b0;
      m_error_code_r  <= 3'd0;
    end else begin
      s_dns_ready_r   <= (state_next_s == S_IDLE);
      m_query_valid_r <= (state_next_s == S_OUT);
      if (load_out_s) begin
        m_dns_id_r     <= (plen_r >= 10'd4) ? hdr_id_s : 16'h0000;
        m_dns_flags_r  <= (plen_r >= 10'd4) ? hdr_flags_s : 16'h0000;
        m_qtype_r      <= qtype_s;
        m_qclass_r     <= qclass_s;
        m_qname_len_r  <= qlen_r;
        m_qname_hash_r <= hash_r;
        m_error_r      <= (code_s != ERR_OK);
        m_error_code_r <= code_s;
      end
    end
  end

  assign s_dns_ready   = s_dns_ready_r;
  assign m_query_valid = m_query_valid_r;
  assign m_src_ip      = src_ip_r;
  assign m_dst_ip      = dst_ip_r;
  assign m_dns_id      = m_dns_id_r;
  assign m_dns_flags   = m_dns_flags_r;
  assign m_qtype       = m_qtype_r;
  assign m_qclass      = m_qclass_r;
  assign m_qname_len   = m_qname_len_r;
  assign m_qname_hash  = m_qname_hash_r;
  assign m_error       = m_error_r;
  assign m_error_code  = m_error_code_r;

endmodule

// File: tb/tb_dns_query_parse.sv
// Directed bench for dns_query_parse: a reference parser builds the expected
// result for each packet and queues it; results are popped and compared when
// the DUT raises m_query_valid.
module tb_dns_query_parse;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_dns_valid = 1'b0;
  logic          s_dns_ready;
  logic [31:0]   s_udp_src_ip = 32'h0;
  logic [31:0]   s_udp_dst_ip = 32'h0;
  logic [15:0]   s_udp_length = 16'h0;
  logic [4095:0] s_dns_pkt = '0;
  logic          m_query_valid;
  logic          m_query_ready = 1'b1;
  logic [31:0]   m_src_ip, m_dst_ip;
  logic [15:0]   m_dns_id, m_dns_flags, m_qtype, m_qclass;
  logic [7:0]    m_qname_len;
  logic [31:0]   m_qname_hash;
  logic          m_error;
  logic [2:0]    m_error_code;

  dns_query_parse dut (
    .clk(clk), .rst(rst),
    .s_dns_valid(s_dns_valid), .s_dns_ready(s_dns_ready),
    .s_udp_src_ip(s_udp_src_ip), .s_udp_dst_ip(s_udp_dst_ip),
    .s_udp_length(s_udp_length), .s_dns_pkt(s_dns_pkt),
    .m_query_valid(m_query_valid), .m_query_ready(m_query_ready),
    .m_src_ip(m_src_ip), .m_dst_ip(m_dst_ip),
    .m_dns_id(m_dns_id), .m_dns_flags(m_dns_flags),
    .m_qtype(m_qtype), .m_qclass(m_qclass),
    .m_qname_len(m_qname_len), .m_qname_hash(m_qname_hash),
    .m_error(m_error), .m_error_code(m_error_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] id;
    logic [15:0] flags;
    logic [15:0] qtype;
    logic [15:0] qclass;
    logic [7:0]  qlen;
    logic [31:0] hash;
    logic [2:0]  code;
    int          lat;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  pb [0:510];
  int          wp;
  exp_t        sb [$];
  exp_t        got;
  logic [31:0] lower_hash;
  bit          seen_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fnv(input logic [31:0] h, input logic [7:0] b);
    logic [7:0] c;
    c = b;
    if (b inside {[8'h41:8'h5A]}) c = b | 8'h20;
    return (h ^ {24'h0, c}) * 32'h01000193;
  endfunction

  // Reference parse of pb[] for a given UDP length, including result latency.
  function automatic exp_t model(input logic [15:0] ulen, input logic [31:0] sip, input logic [31:0] dip);
    exp_t e;
    int plen, ptr, c, b, rem;
    bit done;
    e.sip = sip; e.dip = dip;
    e.qtype = 16'h0; e.qclass = 16'h0; e.qlen = 8'h0;
    e.hash = 32'h811C9DC5; e.code = 3'd0;
    plen = (ulen < 16'd8) ? 0 : int'(ulen) - 8;
    if (plen > 511) plen = 511;
    e.id    = (plen >= 4) ? {pb[0], pb[1]} : 16'h0;
    e.flags = (plen >= 4) ? {pb[2], pb[3]} : 16'h0;
    if (plen < 17) begin
      e.code = 3'd1; e.lat = 2;
    end else if (pb[2][7] || (pb[2][6:3] != 4'd0)) begin
      e.code = 3'd2; e.lat = 2;
    end else if ({pb[4], pb[5]} == 16'h0) begin
      e.code = 3'd3; e.lat = 2;
    end else begin
      ptr = 12; c = 2; done = 1'b0;
      while (!done) begin
        if (ptr >= plen) begin
          e.code = 3'd5; done = 1'b1;
        end else begin
          b = int'(pb[ptr]);
          if (b >= 64) begin
            e.code = 3'd4; done = 1'b1;
          end else if (int'(e.qlen) + 1 + b > 255) begin
            e.code = 3'd6; done = 1'b1;
          end else begin
            e.hash = ref_fnv(e.hash, pb[ptr]); e.qlen++; ptr++;
            if (b == 0) begin
              c++;
              if (ptr + 4 > plen) e.code = 3'd5;
              else begin
                e.qtype  = {pb[ptr], pb[ptr+1]};
                e.qclass = {pb[ptr+2], pb[ptr+3]};
              end
              done = 1'b1;
            end else begin
              rem = b;
              while (rem > 0 && !done) begin
                c++;
                if (ptr >= plen) begin
                  e.code = 3'd5; done = 1'b1;
                end else begin
                  e.hash = ref_fnv(e.hash, pb[ptr]); e.qlen++; ptr++; rem--;
                end
              end
              if (!done) c++;
            end
          end
        end
      end
      e.lat = c + 1;
    end
    return e;
  endfunction

  task automatic clear_pkt();
    for (int i = 0; i < 511; i++) pb[i] = 8'h00;
    wp = 12;
  endtask

  task automatic set_hdr(input logic [15:0] id, input logic [15:0] flags, input logic [15:0] qd);
    pb[0] = id[15:8];    pb[1] = id[7:0];
    pb[2] = flags[15:8]; pb[3] = flags[7:0];
    pb[4] = qd[15:8];    pb[5] = qd[7:0];
  endtask

  task automatic add_byte(input logic [7:0] b);
    pb[wp] = b; wp++;
  endtask

  task automatic add_label(input string s);
    add_byte(8'(s.len()));
    for (int i = 0; i < s.len(); i++) add_byte(s[i]);
  endtask

  task automatic add_name(input string a, input string b, input string c);
    add_label(a); add_label(b); add_label(c); add_byte(8'h00);
  endtask

  // Waits (bounded) for ready, presents the packet for one accepting edge.
  task automatic send(input logic [15:0] ulen, input logic [31:0] sip, input logic [31:0] dip, input bit push);
    int n;
    n = 0;
    while (s_dns_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", {31'h0, s_dns_ready}, 32'h1);
    s_dns_pkt = '0;
    s_dns_pkt[4095:4088] = 8'hA5;
    for (int k = 0; k < 511; k++) s_dns_pkt[4087-8*k -: 8] = pb[k];
    s_udp_length = ulen; s_udp_src_ip = sip; s_udp_dst_ip = dip;
    s_dns_valid = 1'b1;
    if (push) sb.push_back(model(ulen, sip, dip));
    @(posedge clk); #1;
    s_dns_valid = 1'b0;
  endtask

  // Waits (bounded) for a result, pops the scoreboard and compares every field.
  task automatic collect(output exp_t e);
    int c;
    c = 1;
    while (m_query_valid !== 1'b1 && c < 700) begin
      @(posedge clk); #1; c++;
    end
    if (sb.size() == 0) begin
      errors++; checks++;
      $error("FAIL scoreboard_empty observed=result expected=none");
      e = '{default: 0};
    end else begin
      e = sb.pop_front();
      chk("latency",  c,              e.lat);
      chk("valid",    m_query_valid,  1'b1);
      chk("src_ip",   m_src_ip,       e.sip);
      chk("dst_ip",   m_dst_ip,       e.dip);
      chk("id",       m_dns_id,       e.id);
      chk("flags",    m_dns_flags,    e.flags);
      chk("qtype",    m_qtype,        e.qtype);
      chk("qclass",   m_qclass,       e.qclass);
      chk("qlen",     m_qname_len,    e.qlen);
      chk("hash",     m_qname_hash,   e.hash);
      chk("code",     m_error_code,   e.code);
      chk("error",    m_error,        (e.code != 3'd0));
    end
  endtask

  task automatic after_handshake();
    @(posedge clk); #1;
    chk("valid_falls", m_query_valid, 1'b0);
    chk("ready_rises", s_dns_ready,   1'b1);
  endtask

  task automatic build_normal(input logic [15:0] id);
    clear_pkt();
    set_hdr(id, 16'h0100, 16'h0001);
    add_name("www", "example", "com");
    add_byte(8'h00); add_byte(8'h01); add_byte(8'h00); add_byte(8'h01);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", s_dns_ready,   1'b0);
    chk("rst_valid", m_query_valid, 1'b0);
    chk("rst_code",  m_error_code,  3'd0);
    chk("rst_hash",  m_qname_hash,  32'h0);
    chk("rst_id",    m_dns_id,      16'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", s_dns_ready, 1'b1);

    // Normal query www.example.com A/IN
    build_normal(16'h1234);
    lower_hash = model(16'd41, 32'h0, 32'h0).hash;
    send(16'd41, 32'h0A000001, 32'h0A000035, 1'b1);
    chk("ready_drops", s_dns_ready, 1'b0);
    collect(got);
    chk("normal_qlen17",  m_qname_len, 8'd17);
    chk("normal_lat20",   got.lat,     20);
    chk("normal_qtype1",  m_qtype,     16'd1);
    after_handshake();

    // Case folding
    clear_pkt();
    set_hdr(16'hBEEF, 16'h0100, 16'h0001);
    add_name("WWW", "Example", "COM");
    add_byte(8'h00); add_byte(8'h1C); add_byte(8'h00); add_byte(8'h01);
    send(16'd41, 32'hC0A80001, 32'hC0A80002, 1'b1);
    collect(got);
    chk("fold_hash", m_qname_hash, lower_hash);
    after_handshake();

    // NOT_QUERY
    build_normal(16'h5555);
    set_hdr(16'h5555, 16'h8180, 16'h0001);
    send(16'd41, 32'h1, 32'h2, 1'b1);
    collect(got);
    chk("notq_code", m_error_code, 3'd2);
    after_handshake();

    // NO_QUESTION
    build_normal(16'h6666);
    set_hdr(16'h6666, 16'h0100, 16'h0000);
    send(16'd41, 32'h3, 32'h4, 1'b1);
    collect(got);
    after_handshake();

    // SHORT with id/flags still present, then with no payload at all
    build_normal(16'h7777);
    send(16'd20, 32'h5, 32'h6, 1'b1);
    collect(got);
    chk("short_code", m_error_code, 3'd1);
    after_handshake();
    send(16'd5, 32'h7, 32'h8, 1'b1);
    collect(got);
    after_handshake();

    // BAD_LABEL: compression pointer as first QNAME byte
    clear_pkt();
    set_hdr(16'h0A0A, 16'h0100, 16'h0001);
    add_byte(8'hC0); add_byte(8'h0C);
    add_byte(8'h00); add_byte(8'h01); add_byte(8'h00); add_byte(8'h01);
    send(16'd26, 32'h9, 32'hA, 1'b1);
    collect(got);
    chk("bad_qlen0", m_qname_len, 8'd0);
    after_handshake();

    // TRUNC: normal query cut to 30 bytes
    build_normal(16'h0B0B);
    send(16'd38, 32'hB, 32'hC, 1'b1);
    collect(got);
    chk("trunc_code", m_error_code, 3'd5);
    after_handshake();

    // TOO_LONG: four 63-byte labels would total 256 bytes
    clear_pkt();
    set_hdr(16'h0C0C, 16'h0100, 16'h0001);
    for (int l = 0; l < 4; l++) begin
      add_byte(8'd63);
      for (int i = 0; i < 63; i++) add_byte(8'h61 + 8'(l));
    end
    add_byte(8'h00); add_byte(8'h00); add_byte(8'h01); add_byte(8'h00); add_byte(8'h01);
    send(16'd281, 32'hD, 32'hE, 1'b1);
    collect(got);
    chk("toolong_code", m_error_code, 3'd6);
    after_handshake();

    // Back-pressure: hold result for 10 cycles
    m_query_ready = 1'b0;
    build_normal(16'h4321);
    send(16'd41, 32'h11, 32'h22, 1'b1);
    collect(got);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", m_query_valid, 1'b1);
      chk("bp_ready", s_dns_ready,   1'b0);
      chk("bp_hash",  m_qname_hash,  got.hash);
      chk("bp_id",    m_dns_id,      got.id);
    end
    m_query_ready = 1'b1;
    after_handshake();
    build_normal(16'h9999);
    send(16'd41, 32'h33, 32'h44, 1'b1);
    collect(got);
    after_handshake();

    // Reset during LABEL_DATA discards the packet
    build_normal(16'hDEAD);
    send(16'd41, 32'h55, 32'h66, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", m_query_valid, 1'b0);
    chk("midrst_ready", s_dns_ready,   1'b0);
    @(posedge clk); #1;
    chk("midrst_ready_back", s_dns_ready, 1'b1);
    seen_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (m_query_valid === 1'b1) seen_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("midrst_no_output", {31'h0, seen_valid}, 32'h0);
    build_normal(16'hF00D);
    send(16'd41, 32'h77, 32'h88, 1'b1);
    collect(got);
    after_handshake();

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
